// File: rtl/uart_rx_pkg.sv
// Constants and types shared by the UART RX sampling stage and the RX control FSM.
package uart_rx_pkg;

    localparam int unsigned EDGE_W    = 6;
    localparam int unsigned BIT_W     = 4;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned EXT_W     = EDGE_W + 1;

    localparam logic [EDGE_W-1:0] PRESCALE_8  = EDGE_W'(8);
    localparam logic [EDGE_W-1:0] PRESCALE_16 = EDGE_W'(16);
    localparam logic [EDGE_W-1:0] PRESCALE_32 = EDGE_W'(32);

    localparam logic [BIT_W-1:0] BIT_START      = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_PAR        = BIT_W'(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_STOP_NOPAR = BIT_W'(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_STOP_PAR   = BIT_W'(DATA_BITS + 2);

    // Three oversamples taken around the middle of a bit.
    typedef struct packed {
        logic s2;
        logic s1;
        logic s0;
    } samp_t;

    localparam samp_t SAMP_IDLE = samp_t'(3'b111);

    function automatic logic majority3(input samp_t s);
        return (s.s0 & s.s1) | (s.s0 & s.s2) | (s.s1 & s.s2);
    endfunction

    function automatic logic unanimous3(input samp_t s);
        return (s.s0 == s.s1) && (s.s1 == s.s2);
    endfunction

endpackage

// File: rtl/uart_rx_edge_sampler_if.sv
// Signal bundle between the RX control FSM (master) and the edge sampler (slave).
// samp_disagree exists only when SAMPLE_DISAGREE_FLAG_EN is defined.
interface uart_rx_edge_sampler_if;
    import uart_rx_pkg::*;

    logic              RX_IN;
    logic              enable;
    logic              dat_samp_en;
    logic              PAR_EN;
    logic [EDGE_W-1:0] prescale;
    logic [EDGE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              sampled_bit;
`ifdef SAMPLE_DISAGREE_FLAG_EN
    logic              samp_disagree;

    modport slave (
        input  RX_IN, enable, dat_samp_en, PAR_EN, prescale,
        output edge_cnt, bit_cnt, sampled_bit, samp_disagree
    );

    modport master (
        output RX_IN, enable, dat_samp_en, PAR_EN, prescale,
        input  edge_cnt, bit_cnt, sampled_bit, samp_disagree
    );
`else
    modport slave (
        input  RX_IN, enable, dat_samp_en, PAR_EN, prescale,
        output edge_cnt, bit_cnt, sampled_bit
    );

    modport master (
        output RX_IN, enable, dat_samp_en, PAR_EN, prescale,
        input  edge_cnt, bit_cnt, sampled_bit
    );
`endif

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter; frame length follows the
// parity setting latched at the start bit.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable_i,
    input  logic              par_en_i,
    input  logic [EDGE_W-1:0] prescale_i,
    output logic [EDGE_W-1:0] edge_cnt_o,
    output logic [BIT_W-1:0]  bit_cnt_o
);

    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              par_latched_q, par_latched_d;

    logic [EXT_W-1:0]  edge_last_w;
    logic [BIT_W-1:0]  frame_last;
    logic              edge_wrap;
    logic              frame_start;

    // prescale 0 yields an all-ones last edge, i.e. a 64-edge bit.
    always_comb begin
        edge_last_w = {1'b0, prescale_i} - EXT_W'(1);
        frame_last  = par_latched_q ? BIT_STOP_PAR : BIT_STOP_NOPAR;
        edge_wrap   = (edge_cnt_q == edge_last_w[EDGE_W-1:0]);
        frame_start = enable_i && (edge_cnt_q == '0) && (bit_cnt_q == BIT_START);
    end

    always_comb begin
        edge_cnt_d    = '0;
        bit_cnt_d     = '0;
        par_latched_d = par_latched_q;

        if (frame_start) begin
            par_latched_d = par_en_i;
        end

        if (enable_i) begin
            if (edge_wrap) begin
                edge_cnt_d = '0;
                bit_cnt_d  = (bit_cnt_q == frame_last) ? BIT_START
                                                       : bit_cnt_q + BIT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                bit_cnt_d  = bit_cnt_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q    <= '0;
            bit_cnt_q     <= BIT_START;
            par_latched_q <= 1'b0;
        end else begin
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            par_latched_q <= par_latched_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART RX timing stage: edge/bit counters plus a 3-sample majority voter on RX_IN.
// Define SAMPLE_DISAGREE_FLAG_EN to add the samp_disagree noise flag.
module uart_rx_edge_sampler
    import uart_rx_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    uart_rx_edge_sampler_if.slave  bus
);

    logic [EDGE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]  bit_cnt;

    uart_rx_edge_bit_cnt u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .enable_i   (bus.enable),
        .par_en_i   (bus.PAR_EN),
        .prescale_i (bus.prescale),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt)
    );

    // Capture and vote positions, computed one bit wider to absorb wrap.
    logic [EXT_W-1:0]  mid_w;
    logic [EDGE_W-1:0] cap0_edge, cap1_edge, cap2_edge, vote_edge;

    always_comb begin
        mid_w     = {1'b0, bus.prescale} >> 1;
        cap0_edge = EDGE_W'(mid_w - EXT_W'(1));
        cap1_edge = EDGE_W'(mid_w);
        cap2_edge = EDGE_W'(mid_w + EXT_W'(1));
        vote_edge = EDGE_W'(mid_w + EXT_W'(2));
    end

    samp_t samp_q, samp_d;
    logic  sampled_bit_q, sampled_bit_d;
    logic  vote_now;

    always_comb begin
        samp_d        = samp_q;
        sampled_bit_d = sampled_bit_q;
        vote_now      = bus.dat_samp_en && (edge_cnt == vote_edge);

        if (bus.dat_samp_en) begin
            if (edge_cnt == cap0_edge) samp_d.s0 = bus.RX_IN;
            if (edge_cnt == cap1_edge) samp_d.s1 = bus.RX_IN;
            if (edge_cnt == cap2_edge) samp_d.s2 = bus.RX_IN;
        end

        if (vote_now) begin
            sampled_bit_d = majority3(samp_q);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_q        <= SAMP_IDLE;
            sampled_bit_q <= 1'b1;
        end else begin
            samp_q        <= samp_d;
            sampled_bit_q <= sampled_bit_d;
        end
    end

`ifdef SAMPLE_DISAGREE_FLAG_EN
    logic samp_disagree_q, samp_disagree_d;

    // Flags a non-unanimous vote; updated only together with sampled_bit.
    always_comb begin
        samp_disagree_d = samp_disagree_q;
        if (vote_now) begin
            samp_disagree_d = !unanimous3(samp_q);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_disagree_q <= 1'b0;
        end else begin
            samp_disagree_q <= samp_disagree_d;
        end
    end

    assign bus.samp_disagree = samp_disagree_q;
`endif

    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.sampled_bit = sampled_bit_q;

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Scoreboard bench for uart_rx_edge_sampler: a frame-timing reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_uart_rx_edge_sampler;
    import uart_rx_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    uart_rx_edge_sampler_if bus ();

    uart_rx_edge_sampler dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        int   ec;
        int   bc;
        logic samp;
        logic dis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position in the run, current frame start and length.
    int       P;
    int       t_run;
    int       f_start;
    int       f_bits;
    logic [2:0] s;
    logic     m_samp;
    logic     m_dis;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, req, $time);
        end
    endfunction

    function automatic int m_rel();
        return t_run - f_start;
    endfunction

    function automatic int m_edge();
        return m_rel() % P;
    endfunction

    function automatic int m_bit();
        return m_rel() / P;
    endfunction

    function automatic void model_reset();
        t_run   = 0;
        f_start = 0;
        f_bits  = 10;
        s       = 3'b111;
        m_samp  = 1'b1;
        m_dis   = 1'b0;
    endfunction

    function automatic void model_step(input logic en, input logic ds, input logic par, input logic rx);
        int e;
        int mid;
        e   = m_edge();
        mid = P / 2;
        if (ds) begin
            if (e == mid + 2) begin
                m_samp = ($countones(s) >= 2);
                m_dis  = !(s == 3'b000 || s == 3'b111);
            end
            if (e == mid - 1) s[0] = rx;
            if (e == mid)     s[1] = rx;
            if (e == mid + 1) s[2] = rx;
        end
        if (!en) begin
            t_run   = 0;
            f_start = 0;
        end else begin
            if (m_rel() == 0) f_bits = par ? 11 : 10;
            t_run++;
            if (t_run - f_start == f_bits * P) f_start = t_run;
        end
    endfunction

    task automatic cyc(input logic en, input logic ds, input logic par, input logic rx);
        exp_t x;
        bus.enable      = en;
        bus.dat_samp_en = ds;
        bus.PAR_EN      = par;
        bus.RX_IN       = rx;
        @(posedge CLK);
        #1;
        model_step(en, ds, par, rx);
        x.ec   = m_edge();
        x.bc   = m_bit();
        x.samp = m_samp;
        x.dis  = m_dis;
        exp_q.push_back(x);
    endtask

    task automatic set_prescale(input int p);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        bus.prescale = EDGE_W'(p);
        P = (p == 0) ? 64 : p;
    endtask

    task automatic async_reset();
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("rst_edge_cnt", int'(bus.edge_cnt), 0);
        check("rst_bit_cnt", int'(bus.bit_cnt), 0);
        check("rst_sampled_bit", int'(bus.sampled_bit), 1);
`ifdef SAMPLE_DISAGREE_FLAG_EN
        check("rst_samp_disagree", int'(bus.samp_disagree), 0);
`endif
        model_reset();
        #2;
        RST = 1'b1;
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("edge_cnt", int'(bus.edge_cnt), e.ec);
            check("bit_cnt", int'(bus.bit_cnt), e.bc);
            check("sampled_bit", int'(bus.sampled_bit), int'(e.samp));
`ifdef SAMPLE_DISAGREE_FLAG_EN
            check("samp_disagree", int'(bus.samp_disagree), int'(e.dis));
`endif
        end
    end

    initial begin
        int   maxb;
        int   plist[5];
        logic line;
        logic par_r;
        logic ds_r;
        plist = '{8, 16, 32, 12, 0};

        RST             = 1'b0;
        bus.enable      = 1'b0;
        bus.dat_samp_en = 1'b0;
        bus.PAR_EN      = 1'b0;
        bus.RX_IN       = 1'b1;
        bus.prescale    = EDGE_W'(8);
        P               = 8;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("init_edge_cnt", int'(bus.edge_cnt), 0);
        check("init_bit_cnt", int'(bus.bit_cnt), 0);
        check("init_sampled_bit", int'(bus.sampled_bit), 1);
        RST = 1'b1;

        // Prescale 8, no parity: ten 8-edge bits, then back to bit 0.
        for (int i = 0; i < 79; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("p8_last_edge", int'(bus.edge_cnt), 7);
        check("p8_last_bit", int'(bus.bit_cnt), 9);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("p8_wrap_edge", int'(bus.edge_cnt), 0);
        check("p8_wrap_bit", int'(bus.bit_cnt), 0);

        // Prescale 16 with parity, back-to-back frames, PAR_EN dropped mid-frame.
        set_prescale(16);
        maxb = 0;
        for (int i = 0; i < 176; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b1);
            if (int'(bus.bit_cnt) > maxb) maxb = int'(bus.bit_cnt);
        end
        check("par_frame1_max_bit", maxb, 10);
        check("par_frame1_end_bit", int'(bus.bit_cnt), 0);
        maxb = 0;
        for (int i = 0; i < 176; i++) begin
            cyc(1'b1, 1'b0, (i < 20) ? 1'b1 : 1'b0, 1'b1);
            if (int'(bus.bit_cnt) > maxb) maxb = int'(bus.bit_cnt);
        end
        check("par_frame2_max_bit", maxb, 10);
        maxb = 0;
        for (int i = 0; i < 160; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            if (int'(bus.bit_cnt) > maxb) maxb = int'(bus.bit_cnt);
        end
        check("nopar_frame3_max_bit", maxb, 9);
        check("nopar_frame3_end_bit", int'(bus.bit_cnt), 0);

        // Prescale 8: a single low sample at edge 4 is outvoted.
        set_prescale(8);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, (i == 4) ? 1'b0 : 1'b1);
        check("glitch_sampled_bit", int'(bus.sampled_bit), 1);
`ifdef SAMPLE_DISAGREE_FLAG_EN
        check("glitch_disagree", int'(bus.samp_disagree), 1);
`endif

        // Prescale 32: low over edges 15..17 votes 0 and holds while sampling is off.
        set_prescale(32);
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b0, (i >= 15 && i <= 17) ? 1'b0 : 1'b1);
        check("p32_sampled_low", int'(bus.sampled_bit), 0);
`ifdef SAMPLE_DISAGREE_FLAG_EN
        check("p32_unanimous", int'(bus.samp_disagree), 0);
`endif
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("p32_sampled_hold", int'(bus.sampled_bit), 0);

        // Enable dropped at edge 5 of bit 3, then restarted.
        set_prescale(8);
        for (int i = 0; i < 29; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("drop_pre_edge", int'(bus.edge_cnt), 5);
        check("drop_pre_bit", int'(bus.bit_cnt), 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("drop_edge", int'(bus.edge_cnt), 0);
        check("drop_bit", int'(bus.bit_cnt), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("restart_edge", int'(bus.edge_cnt), 1);
        check("restart_bit", int'(bus.bit_cnt), 0);

        // Asynchronous reset in the middle of a bit.
        set_prescale(16);
        for (int i = 0; i < 37; i++) cyc(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        async_reset();

        // Randomized runs across legal and illegal prescale values.
        line  = 1'b1;
        par_r = 1'b0;
        ds_r  = 1'b1;
        for (int seg = 0; seg < 5; seg++) begin
            set_prescale(plist[seg]);
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 19) == 0) line = ~line;
                if ($urandom_range(0, 49) == 0) par_r = ~par_r;
                if ($urandom_range(0, 9) == 0) ds_r = ~ds_r;
                cyc(($urandom_range(0, 999) >= 3) ? 1'b1 : 1'b0,
                    (plist[seg] == 0) ? 1'b0 : ds_r,
                    par_r,
                    ($urandom_range(0, 7) == 0) ? ~line : line);
            end
            if (seg == 2) async_reset();
        end

        @(negedge CLK);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
